// File: rtl/coef_cal_seq.sv
// rtl/coef_cal_seq.sv - frame-synchronous scaler coefficient calculator
// Snapshots the crop window on each accepted vsync rise and commits kX/kY atomically.
module coef_cal_seq #(
  parameter int IN_RES_WIDTH  = 11,
  parameter int OUT_RES_WIDTH = 11,
  parameter int FRAC_BITS     = 6,
  parameter int SCALE_BITS    = 8,
  parameter int FRAME_RATE    = 100,
  parameter int RATE_LIMIT    = 133693440
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     iVsyn,
  input  logic [IN_RES_WIDTH-1:0]  xBgn,
  input  logic [IN_RES_WIDTH-1:0]  xEnd,
  input  logic [IN_RES_WIDTH-1:0]  yBgn,
  input  logic [IN_RES_WIDTH-1:0]  yEnd,
  input  logic [OUT_RES_WIDTH-1:0] outXRes,
  input  logic [OUT_RES_WIDTH-1:0] outYRes,
  output logic [SCALE_BITS-1:0]    kX,
  output logic [SCALE_BITS-1:0]    kY,
  output logic                     inEn,
  output logic                     busy,
  output logic                     err,
  output logic                     coefValid
);

  localparam int DW  = IN_RES_WIDTH + 1 + FRAC_BITS;
  localparam int SW  = IN_RES_WIDTH + 1;
  localparam int VW  = OUT_RES_WIDTH + 1;
  localparam int RMW = VW + 1;
  localparam int PW  = 2 * VW + 8;
  localparam int CW  = $clog2(DW + 1);

  typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, CHECK, COMMIT} state_t;

  state_t          state;
  logic            vsyn_d;
  logic [SW-1:0]   span_y;
  logic [VW-1:0]   div_x;
  logic [VW-1:0]   div_y;
  logic            win_bad;
  logic            rate_ok;
  logic [DW-1:0]   acc;
  logic [VW-1:0]   rem;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   q_x;

  logic            vsyn_rise;
  logic [SW-1:0]   span_x_c;
  logic [SW-1:0]   span_y_c;
  logic [VW-1:0]   divisor;
  logic [RMW-1:0]  trial;
  logic [RMW-1:0]  diff;
  logic            qbit;
  logic [VW-1:0]   rem_next;
  logic [DW-1:0]   q_step;
  logic [PW-1:0]   rate;

  function automatic logic [SCALE_BITS-1:0] sat(input logic [DW-1:0] q);
    if (|q[DW-1:SCALE_BITS]) return '1;
    return q[SCALE_BITS-1:0];
  endfunction

  assign vsyn_rise = iVsyn & ~vsyn_d;

  // One restoring step shared by both axes; acc shifts the dividend out and the quotient in.
  always_comb begin
    span_x_c = SW'(xEnd) - SW'(xBgn) + SW'(1);
    span_y_c = SW'(yEnd) - SW'(yBgn) + SW'(1);
    divisor  = (state == DIV_Y) ? div_y : div_x;
    trial    = {rem, acc[DW-1]};
    diff     = trial - {1'b0, divisor};
    qbit     = (trial >= {1'b0, divisor});
    rem_next = qbit ? diff[VW-1:0] : trial[VW-1:0];
    q_step   = {acc[DW-2:0], qbit};
    rate     = PW'(div_x) * PW'(div_y) * PW'(FRAME_RATE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      vsyn_d    <= 1'b0;
      span_y    <= '0;
      div_x     <= '0;
      div_y     <= '0;
      win_bad   <= 1'b0;
      rate_ok   <= 1'b0;
      acc       <= '0;
      rem       <= '0;
      cnt       <= '0;
      q_x       <= '0;
      kX        <= '0;
      kY        <= '0;
      inEn      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      coefValid <= 1'b0;
    end else begin
      vsyn_d <= iVsyn;
      if (!en) begin
        state <= IDLE;
        busy  <= 1'b0;
        inEn  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (vsyn_rise) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            span_y  <= span_y_c;
            div_x   <= VW'(outXRes) + VW'(1);
            div_y   <= VW'(outYRes) + VW'(1);
            win_bad <= (xEnd < xBgn) | (yEnd < yBgn);
            acc     <= {span_x_c, {FRAC_BITS{1'b0}}};
            rem     <= '0;
            cnt     <= '0;
            state   <= DIV_X;
          end
          DIV_X: begin
            acc <= q_step;
            rem <= rem_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DW - 1)) begin
              q_x   <= q_step;
              acc   <= {span_y, {FRAC_BITS{1'b0}}};
              rem   <= '0;
              cnt   <= '0;
              state <= DIV_Y;
            end
          end
          DIV_Y: begin
            acc <= q_step;
            rem <= rem_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DW - 1)) state <= CHECK;
          end
          CHECK: begin
            rate_ok <= (64'(rate) < 64'(RATE_LIMIT));
            state   <= COMMIT;
          end
          COMMIT: begin
            if (!win_bad && rate_ok) begin
              kX        <= sat(q_x);
              kY        <= sat(acc);
              inEn      <= 1'b1;
              err       <= 1'b0;
              coefValid <= 1'b1;
            end else begin
              inEn <= 1'b0;
              err  <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
